// File: rtl/mem_arbiter_pkg.sv
// Shared types for the memory arbiter: FSM state encoding and grant identifiers.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StGntI = 2'd1,
    StGntD = 2'd2
  } state_e;

  typedef enum logic {
    GntI = 1'b0,
    GntD = 1'b1
  } gnt_e;

  localparam logic [3:0] WstrbLoad = 4'b0000;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter; on a tie the requester not granted last wins.
module rr_arb2
  import mem_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       en_i,
  input  logic [1:0] req_i,
  output logic       valid_o,
  output gnt_e       sel_o
);

  gnt_e last_q, last_d;

  always_comb begin
    valid_o = en_i & (|req_i);
    if (&req_i) begin
      sel_o = (last_q == GntI) ? GntD : GntI;
    end else begin
      sel_o = req_i[1] ? GntD : GntI;
    end
    last_d = valid_o ? sel_o : last_q;
  end

  // Reset to I so that D wins the first tie.
  always_ff @(posedge clk) begin
    if (!reset) begin
      last_q <= GntI;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates instruction-fetch and data requests onto a single memory port,
// with a per-transaction wait timeout. All outputs are registered.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_done,
  output logic        i_err,
  input  logic        d_req,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wstrb,
  output logic        d_done,
  output logic        d_err,
  output logic [31:0] rdata,
  output logic        mem_valid,
  output logic        mem_instr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  state_e        state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic          mem_valid_q, mem_valid_d;
  logic          mem_instr_q, mem_instr_d;
  logic [31:0]   mem_addr_q, mem_addr_d;
  logic [31:0]   mem_wdata_q, mem_wdata_d;
  logic [3:0]    mem_wstrb_q, mem_wstrb_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          i_done_q, i_done_d, i_err_q, i_err_d;
  logic          d_done_q, d_done_d, d_err_q, d_err_d;

  logic [1:0]    arb_req;
  logic          arb_valid;
  gnt_e          arb_sel;

  // A requester is not sampled in the cycle its completion pulse is high.
  assign arb_req = {d_req & ~(d_done_q | d_err_q), i_req & ~(i_done_q | i_err_q)};

  rr_arb2 u_rr_arb2 (
    .clk     (clk),
    .reset   (reset),
    .en_i    (state_q == StIdle),
    .req_i   (arb_req),
    .valid_o (arb_valid),
    .sel_o   (arb_sel)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_valid_d = mem_valid_q;
    mem_instr_d = mem_instr_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    rdata_d     = rdata_q;
    i_done_d    = 1'b0;
    i_err_d     = 1'b0;
    d_done_d    = 1'b0;
    d_err_d     = 1'b0;
    case (state_q)
      StIdle: begin
        if (arb_valid) begin
          mem_valid_d = 1'b1;
          cnt_d       = '0;
          if (arb_sel == GntD) begin
            state_d     = StGntD;
            mem_instr_d = 1'b0;
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
            mem_wstrb_d = d_wstrb;
          end else begin
            state_d     = StGntI;
            mem_instr_d = 1'b1;
            mem_addr_d  = i_addr;
            mem_wdata_d = '0;
            mem_wstrb_d = WstrbLoad;
          end
        end
      end
      StGntI, StGntD: begin
        // A ready on the timeout cycle still completes normally.
        if (mem_ready && mem_valid_q) begin
          state_d     = StIdle;
          mem_valid_d = 1'b0;
          if (mem_wstrb_q == WstrbLoad) rdata_d = mem_rdata;
          if (state_q == StGntI) i_done_d = 1'b1;
          else                   d_done_d = 1'b1;
        end else if (TIMEOUT != 0 && cnt_q == CntW'(TIMEOUT)) begin
          state_d     = StIdle;
          mem_valid_d = 1'b0;
          if (state_q == StGntI) i_err_d = 1'b1;
          else                   d_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d     = StIdle;
        mem_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      mem_valid_q <= 1'b0;
      mem_instr_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= WstrbLoad;
      rdata_q     <= '0;
      i_done_q    <= 1'b0;
      i_err_q     <= 1'b0;
      d_done_q    <= 1'b0;
      d_err_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_valid_q <= mem_valid_d;
      mem_instr_q <= mem_instr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
      rdata_q     <= rdata_d;
      i_done_q    <= i_done_d;
      i_err_q     <= i_err_d;
      d_done_q    <= d_done_d;
      d_err_q     <= d_err_d;
    end
  end

  assign mem_valid = mem_valid_q;
  assign mem_instr = mem_instr_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wstrb = mem_wstrb_q;
  assign rdata     = rdata_q;
  assign i_done    = i_done_q;
  assign i_err     = i_err_q;
  assign d_done    = d_done_q;
  assign d_err     = d_err_q;

endmodule
